// File: rtl/sram_responder_pkg.sv
// ============================================================================
//  Module      : sram_responder_pkg
//  Description : Shared SRAM pin-interface definitions: responder state
//                encodings, default bus widths, active-low pin levels and a
//                cycle classifier used by the responder and its bench.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_responder_pkg;

  // Responder state encodings
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    READ_DRIVE = 2'd2
  } state_t;

  // What the pins request at a sampling edge
  typedef enum logic [1:0] {
    CYC_IDLE  = 2'd0,
    CYC_READ  = 2'd1,
    CYC_WRITE = 2'd2
  } cycle_t;

  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_DATA_WIDTH = 16;

  // CSX/OEX/WEX are active low
  localparam logic PIN_ACTIVE   = 1'b0;
  localparam logic PIN_INACTIVE = 1'b1;

  // Write wins over read; a deselected chip is always idle.
  function automatic cycle_t classify(input logic csx, input logic oex, input logic wex);
    cycle_t kind;
    kind = CYC_IDLE;
    if (csx == PIN_ACTIVE) begin
      if (wex == PIN_ACTIVE) begin
        kind = CYC_WRITE;
      end else if (oex == PIN_ACTIVE) begin
        kind = CYC_READ;
      end
    end
    return kind;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_responder_if.sv
// ============================================================================
//  Module      : sram_responder_if
//  Description : Asynchronous SRAM pin bundle. The shared DATA bus is
//                resolved here from the two possible drivers: the responder
//                (read data) and the controller (write data).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_responder_if
  import sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  CSX;
  logic                  OEX;
  logic                  WEX;
  logic [ADDR_WIDTH-1:0] ADDRESS;

  // Controller-side pad: value and enable for writes
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_en;

  // Responder-side pad: value and enable for reads
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  DRIVING;
  logic                  CONTENTION;

  wire  [DATA_WIDTH-1:0] DATA;

  // Single resolution point for the shared bus. The responder only drives
  // with WEX high, so it never overlaps a legal controller write.
  assign DATA = DRIVING  ? resp_data :
                wdata_en ? wdata     : {DATA_WIDTH{1'bz}};

  modport slave (
    input  CSX, OEX, WEX, ADDRESS, DATA,
    output resp_data, DRIVING, CONTENTION
  );

  modport master (
    output CSX, OEX, WEX, ADDRESS, wdata, wdata_en,
    input  DATA, DRIVING, CONTENTION
  );

endinterface

`default_nettype wire

// File: rtl/sram_responder_storage.sv
// ============================================================================
//  Module      : sram_responder_storage
//  Description : Single-port word array, synchronous write and synchronous
//                read-first output register, shaped for block-RAM inference.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_responder_storage #(
  parameter int ADDR_BITS  = 12,
  parameter int DATA_WIDTH = 16
) (
  input  wire logic                  CLK,
  input  wire logic                  we,
  input  wire logic [ADDR_BITS-1:0]  addr,
  input  wire logic [DATA_WIDTH-1:0] wdata,
  output logic      [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  // Commit writes and register the addressed word every edge
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/sram_responder.sv
// ============================================================================
//  Module      : sram_responder
//  Description : Device-side model of an external asynchronous 16-bit SRAM.
//                Commits writes, answers reads after a programmable latency
//                on the shared DATA bus and flags OEX/WEX contention.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MEM_ADDR_BITS = 12,
  parameter int READ_LATENCY  = 2
) (
  input wire logic      CLK,
  input wire logic      RST,
  sram_responder_if.slave bus
);

  // Wait-counter preload: the transition into READ_DRIVE takes one edge of
  // its own, so the counter covers the remaining READ_LATENCY-2 edges.
  localparam logic [3:0] WAIT_LOAD = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

  cycle_t                   cyc_kind;
  logic                     is_read;
  logic                     is_write;
  logic [MEM_ADDR_BITS-1:0] idx;

  state_t                   state, state_n;
  logic [3:0]               cnt, cnt_n;
  logic [MEM_ADDR_BITS-1:0] rd_addr, rd_addr_n;

  logic [DATA_WIDTH-1:0]    ram_rdata;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     drive_en;
  logic                     contention;

  // Upper address bits alias onto the implemented depth
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.ADDRESS[ADDR_WIDTH-1:MEM_ADDR_BITS];

  assign idx      = bus.ADDRESS[MEM_ADDR_BITS-1:0];
  assign cyc_kind = classify(bus.CSX, bus.OEX, bus.WEX);
  assign is_read  = (cyc_kind == CYC_READ);
  assign is_write = (cyc_kind == CYC_WRITE);

  // The array is always addressed by the live index: whenever a fetch is due
  // (entering or staying in READ_DRIVE) the live index equals rd_addr, and a
  // write also targets the live index. Reset dominates a coincident write.
  sram_responder_storage #(
    .ADDR_BITS  (MEM_ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_storage (
    .CLK   (CLK),
    .we    (is_write & ~RST),
    .addr  (idx),
    .wdata (bus.DATA),
    .rdata (ram_rdata)
  );

  // State, wait counter and latched read index
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rd_addr <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rd_addr <= rd_addr_n;
    end
  end

  // Next-state: start/restart on a new read, count down, hold while driving
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rd_addr_n = rd_addr;
    if (!is_read) begin
      state_n = IDLE;
    end else if ((state == IDLE) || (idx != rd_addr)) begin
      rd_addr_n = idx;
      if (READ_LATENCY == 1) begin
        state_n = READ_DRIVE;
      end else begin
        state_n = READ_WAIT;
        cnt_n   = WAIT_LOAD;
      end
    end else if (state == READ_WAIT) begin
      if (cnt == 4'd0) begin
        state_n = READ_DRIVE;
      end else begin
        cnt_n = cnt - 4'd1;
      end
    end else begin
      state_n = READ_DRIVE;
    end
  end

  // Sticky contention flag, cleared only by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      contention <= 1'b0;
    end else if ((bus.CSX == PIN_ACTIVE) && (bus.OEX == PIN_ACTIVE) && (bus.WEX == PIN_ACTIVE)) begin
      contention <= 1'b1;
    end
  end

  // The array output register is only meaningful once a fetch has landed,
  // which is exactly when the FSM sits in READ_DRIVE.
  assign rd_data = (state == READ_DRIVE) ? ram_rdata : '0;

  // Combinational so the bus is released in the same cycle the master
  // deasserts or changes address, and immediately on reset.
  assign drive_en = (state == READ_DRIVE) && is_read && (idx == rd_addr);

  assign bus.DRIVING    = drive_en;
  assign bus.resp_data  = rd_data;
  assign bus.CONTENTION = contention;

endmodule

`default_nettype wire
